// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
//   Shared definitions for the boot loader and the cpu memory interface.
//   - mem_cmd encodings (same values the cpu FSM drives on mem_cmd)
//   - loader_state_t: loader FSM state encoding
//   - is_write(): decodes a cpu memory command into a RAM write strobe
package prog_loader_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CLEAR   = 3'd2,
    S_RELEASE = 3'd3,
    S_RUN     = 3'd4,
    S_ERROR   = 3'd5
  } loader_state_t;

  function automatic logic is_write(input logic [1:0] cmd);
    return cmd == MWRITE;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if
//   Program word stream into the loader (valid/ready handshake).
//   in_valid  source -> loader  word valid
//   in_data   source -> loader  word
//   in_last   source -> loader  marks the final word of the image
//   in_ready  loader -> source  loader accepts (valid & ready = transfer)
//   master: stream source, slave: loader.
interface prog_loader_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/prog_loader_dffe.sv
// prog_loader_dffe
//   Enabled register with synchronous active-high clear.
//   clk    clock
//   reset  synchronous clear to zero (wins over en)
//   en     load d on the next rising edge
//   d      next value
//   q      registered value
module prog_loader_dffe #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader
//   Boot-time program loader and RAM-port owner. Holds the cpu in reset while a
//   word stream is written into RAM from address 0, optionally zero-fills the
//   rest of the RAM, gives the cpu one reset cycle on the final image, then
//   hands the RAM port to the cpu.
//
//   clk, reset          clock, synchronous active-high reset
//   start               1-cycle pulse: begin a (re)load (honoured in IDLE/RUN/ERROR)
//   stream (slave)      in_valid/in_ready/in_data/in_last word stream
//   cpu_mem_addr/cmd    cpu memory request, routed to RAM in RUN
//   cpu_wdata           cpu write data, routed to RAM in RUN
//   ram_addr/write/din  RAM write/address pins
//   cpu_reset           cpu held in reset everywhere except RUN
//   busy                LOAD or CLEAR in progress
//   done                cpu running on a loaded image
//   err                 image overflowed RAM without in_last
//   word_count          words accepted in the last/current load (saturates at DEPTH)
//
//   state   | meaning
//   IDLE    | after reset, cpu held, waiting for start
//   LOAD    | accepting stream words, each written at cnt
//   CLEAR   | writing zero at cnt every cycle up to DEPTH-1
//   RELEASE | single cycle of cpu reset on the final memory image
//   RUN     | cpu owns the RAM port
//   ERROR   | stream overflowed RAM, cpu held until next start
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 512,
  parameter bit CLEAR_REST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  prog_loader_if.slave      stream,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [1:0]        cpu_mem_cmd,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_din,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] CNT_TOP = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   WC_MAX  = (ADDR_W + 1)'(DEPTH);

  loader_state_t     state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_d;
  logic [ADDR_W:0]   wc, wc_d;
  logic              cnt_en, wc_en;
  logic              start_ok, xfer, at_top;

  // start only matters where a new load may begin
  assign start_ok = start && (state == S_IDLE || state == S_RUN || state == S_ERROR);
  // in_ready is 1 throughout LOAD, so every valid cycle there is a transfer
  assign xfer     = (state == S_LOAD) && stream.in_valid;
  assign at_top   = (cnt == CNT_TOP);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        if (xfer) begin
          if (stream.in_last)
            state_nxt = (CLEAR_REST && !at_top) ? S_CLEAR : S_RELEASE;
          else if (at_top)
            state_nxt = S_ERROR;
        end
      end
      S_CLEAR:   if (at_top) state_nxt = S_RELEASE;
      S_RELEASE: state_nxt = S_RUN;
      S_RUN:     if (start) state_nxt = S_LOAD;
      S_ERROR:   if (start) state_nxt = S_LOAD;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_reset       = (state != S_RUN);
    stream.in_ready = (state == S_LOAD);
    busy            = (state == S_LOAD) || (state == S_CLEAR);
    done            = (state == S_RUN);
    err             = (state == S_ERROR);

    ram_addr  = cnt;
    ram_din   = stream.in_data;
    ram_write = 1'b0;
    unique case (state)
      S_LOAD:  ram_write = stream.in_valid;
      S_CLEAR: begin
        ram_din   = '0;
        ram_write = 1'b1;
      end
      S_RUN: begin
        ram_addr  = cpu_mem_addr;
        ram_din   = cpu_wdata;
        ram_write = is_write(cpu_mem_cmd);
      end
      default: ram_write = 1'b0;
    endcase
  end

  // cnt wraps modulo DEPTH after the last CLEAR write
  always_comb begin
    cnt_en = start_ok || xfer || (state == S_CLEAR);
    cnt_d  = start_ok ? '0 : cnt + ADDR_W'(1);
    wc_en  = start_ok || (xfer && (wc != WC_MAX));
    wc_d   = start_ok ? '0 : wc + (ADDR_W + 1)'(1);
  end

  prog_loader_dffe #(.W(ADDR_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .d     (cnt_d),
    .q     (cnt)
  );

  prog_loader_dffe #(.W(ADDR_W + 1)) u_wc (
    .clk   (clk),
    .reset (reset),
    .en    (wc_en),
    .d     (wc_d),
    .q     (wc)
  );

  assign word_count = wc;

endmodule
